// File: rtl/turn_sched_if.sv
// ============================================================================
// Module   : turn_sched_if
// Desc     : Switch inputs and lamp-request outputs of the turn scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface turn_sched_if;
    logic sw_left;
    logic sw_right;
    logic sw_hazard;
    logic turn_left;
    logic turn_right;
    logic emergency;
    logic blink_tick;
    logic active;

    modport master (
        output sw_left, sw_right, sw_hazard,
        input  turn_left, turn_right, emergency, blink_tick, active
    );

    modport slave (
        input  sw_left, sw_right, sw_hazard,
        output turn_left, turn_right, emergency, blink_tick, active
    );
endinterface

`default_nettype wire

// File: rtl/turn_sched.sv
// ============================================================================
// Module   : turn_sched
// Desc     : Debounces stalk/hazard switches and arbitrates left/right/hazard
//            lamp requests with comfort-blink and auto-cancel timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_sched #(
    parameter int DEBOUNCE_CYC   = 4,
    parameter int TICK_DIV       = 4,
    parameter int MIN_TICKS      = 3,
    parameter int AUTO_OFF_TICKS = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    turn_sched_if.slave bus
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int c_DIV_W  = $clog2(TICK_DIV);
    localparam int c_TICK_W = $clog2(AUTO_OFF_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LEFT   = 2'd1,
        S_RIGHT  = 2'd2,
        S_HAZARD = 2'd3
    } state_t;

    logic [2:0]          w_raw;
    logic [2:0]          w_deb;
    logic                w_haz_rise;
    logic                r_haz_on;
    logic                r_lock_l;
    logic                r_lock_r;
    state_t              r_state;
    state_t              w_next;
    logic                w_set_lock_l;
    logic                w_set_lock_r;
    logic                w_l;
    logic                w_r;
    logic                w_min;
    logic                w_auto;
    logic                w_change;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                r_blink;

    assign w_raw = {bus.sw_hazard, bus.sw_right, bus.sw_left};

    // Per switch: 2-flop synchronizer followed by a consecutive-sample debouncer.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sw
            logic              r_meta;
            logic              r_sync;
            logic              r_deb;
            logic [c_DB_W-1:0] r_cnt;
            logic              w_flip;

            assign w_flip    = (r_sync != r_deb) && (r_cnt == c_DB_W'(DEBOUNCE_CYC - 1));
            assign w_deb[gi] = r_deb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                    r_deb  <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                    if (r_sync == r_deb) begin
                        r_cnt <= '0;
                    end else if (w_flip) begin
                        r_deb <= r_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Toggle on the same edge the debounced hazard rises so hazard and turn
    // requests share the same switch-to-request latency.
    assign w_haz_rise = g_sw[2].w_flip & ~w_deb[2];

    assign w_l    = w_deb[0];
    assign w_r    = w_deb[1];
    assign w_min  = (r_tick_cnt >= c_TICK_W'(MIN_TICKS));
    assign w_auto = (r_tick_cnt >= c_TICK_W'(AUTO_OFF_TICKS));

    always_comb begin
        w_next       = r_state;
        w_set_lock_l = 1'b0;
        w_set_lock_r = 1'b0;
        if (r_haz_on) begin
            w_next = S_HAZARD;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_l && !w_r && !r_lock_l)      w_next = S_LEFT;
                    else if (w_r && !w_l && !r_lock_r) w_next = S_RIGHT;
                end
                S_LEFT: begin
                    if (w_l && !w_r) begin
                        if (w_auto) begin
                            w_next       = S_IDLE;
                            w_set_lock_l = 1'b1;
                        end
                    end else if (!w_l && w_min) begin
                        w_next = (w_r && !r_lock_r) ? S_RIGHT : S_IDLE;
                    end
                end
                S_RIGHT: begin
                    if (w_r && !w_l) begin
                        if (w_auto) begin
                            w_next       = S_IDLE;
                            w_set_lock_r = 1'b1;
                        end
                    end else if (!w_r && w_min) begin
                        w_next = (w_l && !r_lock_l) ? S_LEFT : S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign w_change = (w_next != r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_haz_on <= 1'b0;
            r_lock_l <= 1'b0;
            r_lock_r <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_haz_on <= r_haz_on ^ w_haz_rise;
            if (w_set_lock_l)  r_lock_l <= 1'b1;
            else if (!w_l)     r_lock_l <= 1'b0;
            if (w_set_lock_r)  r_lock_r <= 1'b1;
            else if (!w_r)     r_lock_r <= 1'b0;
        end
    end

    // Blink-step timebase restarts on every state change and idles in IDLE.
    always_ff @(posedge clk) begin
        if (rst || w_change || (r_state == S_IDLE)) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_blink    <= 1'b0;
        end else begin
            r_blink   <= (r_div_cnt == c_DIV_W'(TICK_DIV - 1));
            r_div_cnt <= (r_div_cnt == c_DIV_W'(TICK_DIV - 1)) ? '0 : r_div_cnt + 1'b1;
            if (r_blink && !w_auto) r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign bus.turn_left  = (r_state == S_LEFT);
    assign bus.turn_right = (r_state == S_RIGHT);
    assign bus.emergency  = (r_state == S_HAZARD);
    assign bus.blink_tick = r_blink;
    assign bus.active     = (r_state != S_IDLE);

endmodule

`default_nettype wire
